eight_bit_serial_subtractor: RTL and testbench

EIGHT_BIT_SERIAL_SUBTRACTOR -- requirements
Module: eight_bit_serial_subtractor

---
 rtl/eight_bit_serial_subtractor.sv | 107 ++++++++++
 tb/tb_eight_bit_serial_subtractor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial 8-bit subtractor: latches operands on start, resolves one bit per
// cycle LSB first, then presents diff/borrow_out/overflow with a one-cycle done.
module eight_bit_serial_subtractor (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       borrow_in,
    output logic [7:0] diff,
    output logic       borrow_out,
    output logic       overflow,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] diff_q, diff_d;
    logic [2:0] cnt_q, cnt_d;
    logic       bw_q, bw_d;
    logic       bout_q, bout_d;
    logic       ovf_q, ovf_d;

    logic       a_bit, b_bit, d_bit, bw_nx;
    logic [7:0] acc_nx;

    // Operands stay unshifted so the overflow term can use the latched sign bits.
    always_comb begin
        a_bit  = x_q[cnt_q];
        b_bit  = y_q[cnt_q];
        d_bit  = a_bit ^ b_bit ^ bw_q;
        bw_nx  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
        acc_nx = {d_bit, acc_q[7:1]};
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    bw_d    = borrow_in;
                    cnt_d   = 3'd0;
                    acc_d   = 8'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_nx;
                bw_d  = bw_nx;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    diff_d  = acc_nx;
                    bout_d  = bw_nx;
                    ovf_d   = (x_q[7] ^ y_q[7]) & (acc_nx[7] ^ x_q[7]);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            acc_q   <= 8'd0;
            diff_q  <= 8'd0;
            cnt_q   <= 3'd0;
            bw_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_eight_bit_serial_subtractor.sv
// Scoreboard bench: the driver pushes arithmetic-model results, a negedge
// monitor pops and compares them whenever done is seen.
module tb_eight_bit_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset, start, borrow_in;
    logic [7:0] x, y, diff;
    logic       borrow_out, overflow, busy, done;

    eight_bit_serial_subtractor dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
        .borrow_in(borrow_in), .diff(diff), .borrow_out(borrow_out),
        .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   op_k   = -100;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Plain integer arithmetic: unsigned for diff/borrow, signed range for overflow.
    function automatic exp_t model(input logic [7:0] xa, input logic [7:0] ya,
                                   input logic b, input int k);
        exp_t e;
        int   r, sr;
        r     = int'(xa) - int'(ya) - int'(b);
        sr    = int'($signed(xa)) - int'($signed(ya)) - int'(b);
        e.d   = r[7:0];
        e.bo  = (r < 0);
        e.ov  = (sr < -128) || (sr > 127);
        e.cyc = k + 8;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the op is back in IDLE.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] ya,
                         input logic b, input bit noise);
        start = 1'b1; x = xa; y = ya; borrow_in = b;
        op_k = cyc + 1;
        sb.push_back(model(xa, ya, b, cyc + 1));
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            x         = 8'($urandom);
            y         = 8'($urandom);
            borrow_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin : monitor
        logic       prev_done = 1'b0;
        logic [7:0] prev_diff = 8'd0;
        logic       prev_bo = 1'b0, prev_ov = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("busy", int'(busy), int'(op_k >= 0 && cyc >= op_k && cyc <= op_k + 8));
                if (done) begin
                    check("done_pulse", int'(prev_done), 0);
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("diff", int'(diff), int'(e.d));
                        check("borrow_out", int'(borrow_out), int'(e.bo));
                        check("overflow", int'(overflow), int'(e.ov));
                        check("latency", cyc, e.cyc);
                    end
                end else begin
                    check("result_hold", int'({diff, borrow_out, overflow}),
                          int'({prev_diff, prev_bo, prev_ov}));
                end
            end
            prev_done = done;
            prev_diff = diff;
            prev_bo   = borrow_out;
            prev_ov   = overflow;
        end
    end

    initial begin : driver
        reset = 1'b1; start = 1'b0; x = 8'd0; y = 8'd0; borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(borrow_out), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        do_op(8'h50, 8'h30, 1'b0, 1'b0);
        do_op(8'h30, 8'h50, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 1'b0);

        // Restart attempt mid-operation with different operands must be ignored.
        start = 1'b1; x = 8'h50; y = 8'h30; borrow_in = 1'b0;
        op_k = cyc + 1;
        sb.push_back(model(8'h50, 8'h30, 1'b0, cyc + 1));
        @(negedge clk); start = 1'b0; x = 8'h11; y = 8'h22;
        @(negedge clk);
        @(negedge clk); start = 1'b1; x = 8'hFF; y = 8'h00;
        @(negedge clk); start = 1'b0; x = 8'h5A; y = 8'hA5; borrow_in = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("no_extra_done", sb.size(), 0);

        // Asynchronous reset while bit 4 is pending aborts the op with no done.
        start = 1'b1; x = 8'h50; y = 8'h30; borrow_in = 1'b0;
        op_k = cyc + 1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1; op_k = -100;
        #1;
        check("abort_diff", int'(diff), 0);
        check("abort_bout", int'(borrow_out), 0);
        check("abort_ovf", int'(overflow), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        do_op(8'h10, 8'h01, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
